// File: rtl/fft_frame_feeder.sv
// Single-buffer frame source for the burst FFT input: fills a RAM from the sample stream,
// then replays it as one AXI-stream burst on request.
module fft_frame_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axi_valid,
  input  logic [2*DATA_WIDTH-1:0] s_axi_data,
  input  logic                    fft_start,
  output logic                    m_axi_valid,
  input  logic                    m_axi_ready,
  output logic [2*DATA_WIDTH-1:0] m_axi_data,
  output logic                    m_axi_last,
  output logic                    frame_ready,
  output logic                    overflow
);

  localparam int unsigned AW         = ADDR_WIDTH + 1;
  localparam int unsigned SW         = 2 * DATA_WIDTH;
  localparam int unsigned FFT_LENGTH = 2 ** AW;
  localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

  typedef enum logic [1:0] {StFill, StFull, StSend} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            rd_done_q, rd_done_d;
  logic            start_pending_q, start_pending_d;
  logic            overflow_q;

  logic            wr_en, rd_en, send_start, pop, out_free;
  logic [1:0]      occupancy;

  logic [SW-1:0]   mem [FFT_LENGTH];
  logic [SW-1:0]   ram_q;
  logic            ram_valid_q, ram_last_q;

  logic            out_valid_q, out_last_q;
  logic [SW-1:0]   out_data_q;
  logic            skid_valid_q, skid_last_q;
  logic [SW-1:0]   skid_data_q;

  assign pop      = out_valid_q & m_axi_ready;
  assign out_free = ~out_valid_q | m_axi_ready;
  // Entries that will sit in out/skid after this edge; a new read needs one free slot left.
  assign occupancy = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(ram_valid_q) - 2'(pop);

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_done_d  = rd_done_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    send_start = 1'b0;
    unique case (state_q)
      StFill: begin
        if (s_axi_valid) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == LastAddr) state_d = StFull;
        end
      end
      StFull: begin
        if (start_pending_q || fft_start) begin
          state_d    = StSend;
          send_start = 1'b1;
        end
      end
      StSend: begin
        if (!rd_done_q && occupancy <= 2'd1) begin
          rd_en     = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == LastAddr) rd_done_d = 1'b1;
        end
        if (pop && out_last_q) begin
          state_d   = StFill;
          wr_addr_d = '0;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
    start_pending_d = (start_pending_q | fft_start) & ~send_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StFill;
      wr_addr_q       <= '0;
      rd_addr_q       <= '0;
      rd_done_q       <= 1'b0;
      start_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_addr_q       <= wr_addr_d;
      rd_addr_q       <= rd_addr_d;
      rd_done_q       <= rd_done_d;
      start_pending_q <= start_pending_d;
      overflow_q      <= s_axi_valid & (state_q != StFill);
    end
  end

  // Buffer RAM: simple dual port, registered read, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q] <= s_axi_data;
    if (rd_en) ram_q <= mem[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_valid_q  <= 1'b0;
      ram_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      ram_valid_q <= rd_en;
      ram_last_q  <= rd_en & (rd_addr_q == LastAddr);
      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_data_q   <= skid_data_q;
          out_last_q   <= skid_last_q;
          skid_valid_q <= ram_valid_q;
          if (ram_valid_q) begin
            skid_data_q <= ram_q;
            skid_last_q <= ram_last_q;
          end
        end else begin
          out_valid_q <= ram_valid_q;
          out_last_q  <= ram_valid_q & ram_last_q;
          if (ram_valid_q) out_data_q <= ram_q;
        end
      end else if (ram_valid_q) begin
        // Output stalled: park the in-flight RAM word instead of losing it.
        skid_valid_q <= 1'b1;
        skid_data_q  <= ram_q;
        skid_last_q  <= ram_last_q;
      end
    end
  end

  assign m_axi_valid = out_valid_q;
  assign m_axi_data  = out_data_q;
  assign m_axi_last  = out_last_q;
  assign frame_ready = (state_q == StFull);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with an 8-sample frame; inputs driven and outputs
// sampled on the falling edge.
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_axi_valid;
  logic [31:0] s_axi_data;
  logic        fft_start;
  logic        m_axi_valid;
  logic        m_axi_ready;
  logic [31:0] m_axi_data;
  logic        m_axi_last;
  logic        frame_ready;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_cnt  = 0;

  logic [31:0] beat_q[$];
  logic        last_q[$];
  bit          hold_chk = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  fft_frame_feeder #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi_valid(s_axi_valid),
    .s_axi_data (s_axi_data),
    .fft_start  (fft_start),
    .m_axi_valid(m_axi_valid),
    .m_axi_ready(m_axi_ready),
    .m_axi_data (m_axi_data),
    .m_axi_last (m_axi_last),
    .frame_ready(frame_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: inputs set here are taken at the next rising edge.
  task automatic drive(input logic sv, input logic [31:0] sd, input logic st, input logic rdy);
    @(negedge clk);
    if (hold_chk) begin
      check_eq("hold_valid", m_axi_valid, 1);
      check_eq("hold_data", m_axi_data, held_data);
      check_eq("hold_last", m_axi_last, held_last);
    end
    if (overflow) ovf_cnt++;
    s_axi_valid = sv;
    s_axi_data  = sd;
    fft_start   = st;
    m_axi_ready = rdy;
    if (m_axi_valid && rdy) begin
      beat_q.push_back(m_axi_data);
      last_q.push_back(m_axi_last);
    end
    hold_chk  = m_axi_valid && !rdy;
    held_data = m_axi_data;
    held_last = m_axi_last;
  endtask

  task automatic fill(input logic [31:0] base, input logic [7:0] starts);
    for (int i = 0; i < 8; i++) drive(1'b1, base + 32'(i), starts[i], 1'b1);
  endtask

  task automatic collect(input int n, input bit toggle);
    int cyc = 0;
    bit rdy = 1'b1;
    while (beat_q.size() < n && cyc < 80) begin
      drive(1'b0, 32'h0, 1'b0, toggle ? rdy : 1'b1);
      rdy = !rdy;
      cyc++;
    end
    if (beat_q.size() < n) check_eq("collect_timeout", beat_q.size(), n);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] first, input int n);
    check_eq({tag, "_count"}, beat_q.size(), n);
    for (int i = 0; i < beat_q.size() && i < n; i++) begin
      check_eq({tag, "_data"}, beat_q[i], first + 32'(i));
      check_eq({tag, "_last"}, last_q[i], (i == 7));
    end
    beat_q.delete();
    last_q.delete();
  endtask

  task automatic check_outputs_clear(input string tag);
    check_eq({tag, "_valid"}, m_axi_valid, 0);
    check_eq({tag, "_last"}, m_axi_last, 0);
    check_eq({tag, "_data"}, m_axi_data, 0);
    check_eq({tag, "_frame_ready"}, frame_ready, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    s_axi_valid = 1'b0;
    fft_start   = 1'b0;
    m_axi_ready = 1'b1;
    hold_chk    = 1'b0;
    #1;
    check_outputs_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;
    beat_q.delete();
    last_q.delete();
  endtask

  initial begin
    rst_n       = 1'b0;
    s_axi_valid = 1'b0;
    s_axi_data  = '0;
    fft_start   = 1'b0;
    m_axi_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_clear("por");
    rst_n = 1'b1;

    // Basic flow: start with sample 3, frame_ready one cycle after sample 8.
    fill(32'd1, 8'b0000_0100);
    check_eq("basic_fr_before", frame_ready, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("basic_fr_full", frame_ready, 1);
    check_eq("basic_valid_full", m_axi_valid, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("basic_fr_send", frame_ready, 0);
    check_eq("basic_valid_s0", m_axi_valid, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("basic_valid_s1", m_axi_valid, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("basic_valid_s2", m_axi_valid, 1);
    check_eq("basic_first", m_axi_data, 32'd1);
    collect(8, 1'b0);
    check_frame("basic", 32'd1, 8);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("basic_end_valid", m_axi_valid, 0);
    check_eq("basic_end_last", m_axi_last, 0);

    // Backpressure with ready toggling.
    fill(32'h21, 8'b0000_0001);
    collect(8, 1'b1);
    check_frame("bp", 32'h21, 8);

    // Samples during SEND are dropped and flagged.
    ovf_cnt = 0;
    fill(32'h31, 8'b0000_0001);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    collect(8, 1'b0);
    check_eq("ovf_count", ovf_cnt, 3);
    check_frame("ovf_frame", 32'h31, 8);

    // Two starts in FILL give one frame; next frame waits in FULL.
    fill(32'h41, 8'b0000_0101);
    collect(8, 1'b0);
    check_frame("dbl_start", 32'h41, 8);
    fill(32'h51, 8'b0000_0000);
    repeat (4) drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("wait_fr", frame_ready, 1);
    check_eq("wait_valid", m_axi_valid, 0);
    check_eq("wait_beats", beat_q.size(), 0);

    // Reset mid-SEND with a start pending; pending must be discarded.
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    collect(2, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    collect(4, 1'b0);
    check_frame("pre_rst", 32'h51, 4);
    do_reset();
    fill(32'h61, 8'b0000_0000);
    repeat (4) drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("post_rst_fr", frame_ready, 1);
    check_eq("post_rst_valid", m_axi_valid, 0);
    check_eq("post_rst_beats", beat_q.size(), 0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    collect(8, 1'b0);
    check_frame("post_rst", 32'h61, 8);

    // Closed loop: start = registered (valid & last), plus one pulse after reset.
    do_reset();
    ovf_cnt = 0;
    begin
      logic        st  = 1'b1;
      logic [31:0] seq = 32'd1;
      int          cyc = 0;
      while (beat_q.size() < 16 && cyc < 120) begin
        drive(1'b1, seq, st, 1'b1);
        st = m_axi_valid & m_axi_last;
        seq++;
        cyc++;
      end
    end
    if (beat_q.size() < 16) check_eq("loop_timeout", beat_q.size(), 16);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("loop_count", beat_q.size(), 16);
    for (int i = 0; i < beat_q.size() && i < 16; i++) begin
      check_eq("loop_data", beat_q[i], (i < 8) ? 32'(1 + i) : 32'(20 + i - 8));
      check_eq("loop_last", last_q[i], (i % 8 == 7));
    end
    check_eq("loop_ovf", ovf_cnt, 22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
